ex_mem_skid_reg: RTL and testbench
==================================

Name: ex_mem_skid_reg

Overview:
- Parametrised elastic EX→MEM pipeline register for the RV32I pipeline; successor to the plain EX/MEM latch.
- Adds valid/ready handshake, a 2-entry skid buffer so ReadyE is registered (no combinational ready path), synchronous flush, x0 write canonicalisation, and qualified forwarding outputs for the hazard unit.
- Sits between the execute stage (ALU) and the memory stage (data memory port).

Parameters:
- XLEN, 32, width of ALUResult, DataW and PCPlus4.
- RA_W, 5, register address width.
- RS_W, 2, ResultSrc control width.
- CANON_X0, 1, when 1 a write to x0 is captured with RegWrite=0.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-high reset
- FlushM  input  1  synchronous kill of all held entries
- ValidE  input  1  EX offers an instruction
- ReadyE  output  1  block can accept (registered)
- ALUResultE  input  XLEN  ALU result
- DataWE  input  XLEN  store data
- PCPlus4E  input  XLEN  link value
- RdE  input  RA_W  destination register
- RegWriteE  input  1  register write enable
- MemWriteE  input  1  store enable
- ResultSrcE  input  RS_W  writeback mux select
- Funct3E  input  3  load/store size code
- ValidM  output  1  MEM side holds an instruction
- ReadyM  input  1  MEM stage consumes
- ALUResultM, DataWM, PCPlus4M  output  XLEN  registered payload
- RdM  output  RA_W
- RegWriteM, MemWriteM  output  1
- ResultSrcM  output  RS_W
- Funct3M  output  3
- FwdRdM  output  RA_W  RdM if ValidM&RegWriteM&(RdM≠0), else 0
- OccM  output  2  entries held (0..2)

Behaviour:
- Storage: main slot (drives all *M outputs) and skid slot, each with a valid bit. ValidM = main_valid. ReadyE = ~skid_valid, taken straight from the flop.
- acceptE = ValidE & ReadyE. drainM = ValidM & ReadyM.
- Priority: reset > FlushM > normal operation.
- Reset (async, on posedge reset):
  - both valids 0; all payload regs 0.
  - Hence ValidM=0, all *M outputs 0, FwdRdM=0, OccM=0, ReadyE=1.
- FlushM=1 at an edge:
  - both valids cleared.
  - Any acceptE in the same cycle is dropped.
  - Payload registers keep their values (don't-care).
  - ReadyE=1 the next cycle.
- Normal operation:
  - main empty or draining, skid empty, acceptE: input → main. Latency is 1 cycle.
  - main full, not draining, acceptE: input → skid. ReadyE drops the next cycle.
  - drainM with skid full: skid → main, skid cleared. No accept is possible this cycle (ReadyE=0).
  - drainM with skid empty and no acceptE: main_valid → 0.
- Sustained throughput is 1 instruction/cycle with ReadyM held at 1.
- Stability: while ValidM & ~ReadyM, all *M outputs hold constant.
- Ordering: in-order. The skid entry is never presented before the main entry.
- CANON_X0=1: the captured RegWrite is RegWriteE & (RdE≠0). Rd is stored unmodified.
- OccM = main_valid + skid_valid. OccM=2 implies ReadyE=0.
- No arithmetic on the payload. Pure capture.
- Reset asserted mid-transfer: the entry is lost. ValidM=0 immediately (asynchronous).

Decomposition:
- Shared pipeline package (pipe_pkg):
  - ex_mem_t packed struct holding ALUResult, DataW, PCPlus4, Rd, RegWrite, MemWrite, ResultSrc, Funct3.
  - ResultSrc encodings (RS_ALU, RS_MEM, RS_PC4).
  - Funct3 load/store constants.
- One generic sub-module, skid_slot_ctrl, holds the two valid flops, the ready logic and the move/load enables, parameter-free. It is reused for the ID/EX and MEM/WB successors.
- The payload mux/regs stay in ex_mem_skid_reg.

Test Plan:
- Reset → ValidM=0, OccM=0, ReadyE=1, ALUResultM=0. Release reset, ValidE=1, ALUResultE=0x0000_1234, RdE=5, RegWriteE=1, ReadyM=1 → next cycle ValidM=1, ALUResultM=0x1234, FwdRdM=5.
- Stream of 8 back-to-back instructions (ALUResult 1..8), ReadyM=1 → ValidM high 8 consecutive cycles, values 1..8 in order, ReadyE never low.
- ReadyM=0 while sending A=0xA, B=0xB → OccM=2, ReadyE=0, ALUResultM holds 0xA. Raise ReadyM → 0xA drains, then 0xB, then ValidM=0.
- OccM=2, FlushM=1 with ValidE=1 → next cycle ValidM=0, OccM=0, ReadyE=1, flushed input not seen at output.
- RdE=0, RegWriteE=1, CANON_X0=1 → RegWriteM=0, FwdRdM=0. With CANON_X0=0 → RegWriteM=1, FwdRdM=0.
- Assert reset asynchronously mid-cycle with OccM=2 → ValidM falls before the next clock edge, all *M outputs=0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared RV32I pipeline types: EX/MEM payload layout, writeback select codes, load/store sizes.
package pipe_pkg;

  typedef enum logic [1:0] {
    RS_ALU = 2'd0,
    RS_MEM = 2'd1,
    RS_PC4 = 2'd2
  } result_src_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] data_w;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_write;
    logic [1:0]  result_src;
    logic [2:0]  funct3;
  } ex_mem_t;

endpackage

// File: rtl/skid_slot_ctrl.sv
// Two-entry skid control: main/skid valid flops, registered upstream ready, payload load/move enables.
// Payload storage lives in the owning stage register; this block only says when to load or move it.
module skid_slot_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_flush,
  input  logic       i_valid_in,
  input  logic       i_ready_out,
  output logic       o_ready_in,
  output logic       o_valid_out,
  output logic       o_load_main,
  output logic       o_load_skid,
  output logic       o_move_skid,
  output logic [1:0] o_occ
);

  logic r_main_vld;
  logic r_skid_vld;
  logic w_accept;
  logic w_drain;

  assign w_accept = i_valid_in & ~r_skid_vld;
  assign w_drain  = r_main_vld & i_ready_out;

  // Skid can only fill while main is stalled, so a full skid always has a full main ahead of it.
  assign o_load_main = ~i_flush & w_accept & (~r_main_vld | w_drain);
  assign o_load_skid = ~i_flush & w_accept & r_main_vld & ~w_drain;
  assign o_move_skid = ~i_flush & r_skid_vld & w_drain;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (i_flush) begin
      r_main_vld <= 1'b0;
      r_skid_vld <= 1'b0;
    end else if (o_move_skid) begin
      r_skid_vld <= 1'b0;
    end else if (o_load_main) begin
      r_main_vld <= 1'b1;
    end else if (o_load_skid) begin
      r_skid_vld <= 1'b1;
    end else if (w_drain) begin
      r_main_vld <= 1'b0;
    end
  end

  assign o_ready_in  = ~r_skid_vld;
  assign o_valid_out = r_main_vld;
  assign o_occ       = {1'b0, r_main_vld} + {1'b0, r_skid_vld};

endmodule

// File: rtl/ex_mem_skid_reg.sv
// Elastic EX->MEM register with 2-entry skid buffer, synchronous flush and x0 write canonicalisation.
// Latency 1 cycle; ReadyE comes straight from a flop so no combinational ready path reaches EX.
module ex_mem_skid_reg
  import pipe_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RA_W     = 5,
  parameter int RS_W     = 2,
  parameter int CANON_X0 = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            FlushM,
  input  logic            ValidE,
  output logic            ReadyE,
  input  logic [XLEN-1:0] ALUResultE,
  input  logic [XLEN-1:0] DataWE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [RA_W-1:0] RdE,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic [RS_W-1:0] ResultSrcE,
  input  logic [2:0]      Funct3E,
  output logic            ValidM,
  input  logic            ReadyM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] DataWM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [RA_W-1:0] RdM,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [RS_W-1:0] ResultSrcM,
  output logic [2:0]      Funct3M,
  output logic [RA_W-1:0] FwdRdM,
  output logic [1:0]      OccM
);

  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] data_w;
    logic [XLEN-1:0] pc_plus4;
    logic [RA_W-1:0] rd;
    logic            reg_write;
    logic            mem_write;
    logic [RS_W-1:0] result_src;
    logic [2:0]      funct3;
  } pay_t;

  pay_t r_main;
  pay_t r_skid;
  pay_t w_in;
  logic w_load_main;
  logic w_load_skid;
  logic w_move_skid;
  logic w_reg_write;

  // Rd stays as issued; only the write enable is squashed for x0.
  assign w_reg_write = (CANON_X0 != 0) ? (RegWriteE & (RdE != '0)) : RegWriteE;

  assign w_in = '{alu_result: ALUResultE, data_w: DataWE, pc_plus4: PCPlus4E, rd: RdE,
                  reg_write: w_reg_write, mem_write: MemWriteE, result_src: ResultSrcE,
                  funct3: Funct3E};

  skid_slot_ctrl u_ctrl (
    .clk         (clk),
    .reset       (reset),
    .i_flush     (FlushM),
    .i_valid_in  (ValidE),
    .i_ready_out (ReadyM),
    .o_ready_in  (ReadyE),
    .o_valid_out (ValidM),
    .o_load_main (w_load_main),
    .o_load_skid (w_load_skid),
    .o_move_skid (w_move_skid),
    .o_occ       (OccM)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_move_skid) begin
        r_main <= r_skid;
      end else if (w_load_main) begin
        r_main <= w_in;
      end
      if (w_load_skid) begin
        r_skid <= w_in;
      end
    end
  end

  assign ALUResultM = r_main.alu_result;
  assign DataWM     = r_main.data_w;
  assign PCPlus4M   = r_main.pc_plus4;
  assign RdM        = r_main.rd;
  assign RegWriteM  = r_main.reg_write;
  assign MemWriteM  = r_main.mem_write;
  assign ResultSrcM = r_main.result_src;
  assign Funct3M    = r_main.funct3;
  assign FwdRdM     = (ValidM & r_main.reg_write & (r_main.rd != '0)) ? r_main.rd : '0;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Scoreboard bench: driver pushes accepted instructions into an in-order queue, monitor pops on each MEM transfer.
module tb_ex_mem_skid_reg;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        FlushM, ValidE, ReadyM;
  logic [31:0] ALUResultE, DataWE, PCPlus4E;
  logic [4:0]  RdE;
  logic        RegWriteE, MemWriteE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  Funct3E;

  logic        ReadyE, ValidM, RegWriteM, MemWriteM;
  logic [31:0] ALUResultM, DataWM, PCPlus4M;
  logic [4:0]  RdM, FwdRdM;
  logic [1:0]  ResultSrcM, OccM;
  logic [2:0]  Funct3M;

  logic        ReadyE0, ValidM0, RegWriteM0, MemWriteM0;
  logic [31:0] ALUResultM0, DataWM0, PCPlus4M0;
  logic [4:0]  RdM0, FwdRdM0;
  logic [1:0]  ResultSrcM0, OccM0;
  logic [2:0]  Funct3M0;

  int errors = 0;
  int checks = 0;
  ex_mem_t q[$];

  always #5 clk = ~clk;

  ex_mem_skid_reg dut (
    .clk(clk), .reset(reset), .FlushM(FlushM), .ValidE(ValidE), .ReadyE(ReadyE),
    .ALUResultE(ALUResultE), .DataWE(DataWE), .PCPlus4E(PCPlus4E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .Funct3E(Funct3E),
    .ValidM(ValidM), .ReadyM(ReadyM), .ALUResultM(ALUResultM), .DataWM(DataWM),
    .PCPlus4M(PCPlus4M), .RdM(RdM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .FwdRdM(FwdRdM), .OccM(OccM)
  );

  ex_mem_skid_reg #(.CANON_X0(0)) dut0 (
    .clk(clk), .reset(reset), .FlushM(FlushM), .ValidE(ValidE), .ReadyE(ReadyE0),
    .ALUResultE(ALUResultE), .DataWE(DataWE), .PCPlus4E(PCPlus4E), .RdE(RdE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE), .Funct3E(Funct3E),
    .ValidM(ValidM0), .ReadyM(ReadyM), .ALUResultM(ALUResultM0), .DataWM(DataWM0),
    .PCPlus4M(PCPlus4M0), .RdM(RdM0), .RegWriteM(RegWriteM0), .MemWriteM(MemWriteM0),
    .ResultSrcM(ResultSrcM0), .Funct3M(Funct3M0), .FwdRdM(FwdRdM0), .OccM(OccM0)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus. Inputs change on the falling edge; the model state is compared
  // before the accept decision so the queue depth mirrors what the DUT holds right now.
  task automatic cyc(input logic v, input logic [31:0] alu, input logic [4:0] rd,
                     input logic rw, input logic rm, input logic fl);
    ex_mem_t e;
    @(negedge clk);
    e.alu_result = alu;
    e.data_w     = $urandom;
    e.pc_plus4   = $urandom;
    e.rd         = rd;
    e.reg_write  = rw;
    e.mem_write  = 1'($urandom_range(0, 1));
    e.result_src = 2'($urandom_range(0, 2));
    e.funct3     = 3'($urandom_range(0, 7));
    ValidE = v; FlushM = fl; ReadyM = fl ? 1'b0 : rm;
    ALUResultE = e.alu_result; DataWE = e.data_w; PCPlus4E = e.pc_plus4; RdE = e.rd;
    RegWriteE = e.reg_write; MemWriteE = e.mem_write; ResultSrcE = e.result_src; Funct3E = e.funct3;
    #1;
    chk("occ", OccM, q.size());
    chk("ready_e", ReadyE, q.size() < 2);
    chk("valid_m", ValidM, q.size() != 0);
    chk("valid_m_nocanon", ValidM0, q.size() != 0);
    if (fl) q.delete();
    else if (v && ReadyE) q.push_back(e);
  endtask

  // Monitor: every MEM-side transfer must be the oldest outstanding accepted instruction.
  logic         prev_hold = 1'b0;
  logic [107:0] prev_pay;
  always @(negedge clk) begin
    ex_mem_t e;
    logic [107:0] pay;
    #2;
    pay = {ALUResultM, DataWM, PCPlus4M, RdM, RegWriteM, MemWriteM, ResultSrcM, Funct3M};
    if (!reset) begin
      if (prev_hold && ValidM) chk("hold_stable", pay, prev_pay);
      if (ValidM && ReadyM) begin
        if (q.size() == 0) begin
          chk("unexpected_out", ALUResultM, 32'hxxxx_xxxx);
        end else begin
          e = q.pop_front();
          chk("alu", ALUResultM, e.alu_result);
          chk("dataw", DataWM, e.data_w);
          chk("pc4", PCPlus4M, e.pc_plus4);
          chk("rd", RdM, e.rd);
          chk("regwrite", RegWriteM, e.reg_write && e.rd != 0);
          chk("memwrite", MemWriteM, e.mem_write);
          chk("resultsrc", ResultSrcM, e.result_src);
          chk("funct3", Funct3M, e.funct3);
          chk("fwdrd", FwdRdM, (e.reg_write && e.rd != 0) ? e.rd : 5'd0);
          chk("regwrite_nocanon", RegWriteM0, e.reg_write);
          chk("fwdrd_nocanon", FwdRdM0, (e.reg_write && e.rd != 0) ? e.rd : 5'd0);
        end
      end
    end
    prev_hold = ValidM && !ReadyM && !reset;
    prev_pay  = pay;
  end

  initial begin
    reset = 1'b0; FlushM = 0; ValidE = 0; ReadyM = 0;
    ALUResultE = 0; DataWE = 0; PCPlus4E = 0; RdE = 0;
    RegWriteE = 0; MemWriteE = 0; ResultSrcE = 0; Funct3E = 0;
    #1 reset = 1'b1;
    #2;
    chk("rst_valid", ValidM, 0);
    chk("rst_occ", OccM, 0);
    chk("rst_ready", ReadyE, 1);
    chk("rst_alu", ALUResultM, 0);
    chk("rst_fwd", FwdRdM, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // First instruction, 1-cycle latency
    cyc(1, 32'h1234, 5'd5, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("lat_valid", ValidM, 1);
    chk("lat_alu", ALUResultM, 32'h1234);
    chk("lat_fwd", FwdRdM, 5);

    // Back-to-back stream at full rate
    for (int i = 1; i <= 8; i++) begin
      cyc(1, i, 5'(i + 3), 1, 1, 0);
      chk("stream_ready", ReadyE, 1);
    end
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);

    // Stall: A in main, B in skid
    cyc(1, 32'hA, 5'd1, 1, 0, 0);
    cyc(1, 32'hB, 5'd2, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("stall_occ", OccM, 2);
    chk("stall_ready", ReadyE, 0);
    chk("stall_alu", ALUResultM, 32'hA);
    repeat (3) cyc(0, 0, 0, 0, 1, 0);

    // Flush with both slots full and a new offer
    cyc(1, 32'h11, 5'd3, 1, 0, 0);
    cyc(1, 32'h22, 5'd4, 1, 0, 0);
    cyc(1, 32'hDEAD, 5'd6, 1, 0, 1);
    cyc(0, 0, 0, 0, 1, 0);
    chk("flush_valid", ValidM, 0);
    chk("flush_occ", OccM, 0);
    chk("flush_ready", ReadyE, 1);
    cyc(0, 0, 0, 0, 1, 0);

    // Write to x0
    cyc(1, 32'h55, 5'd0, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("x0_regwrite", RegWriteM, 0);
    chk("x0_fwd", FwdRdM, 0);
    chk("x0_regwrite_nocanon", RegWriteM0, 1);
    chk("x0_fwd_nocanon", FwdRdM0, 0);
    cyc(0, 0, 0, 0, 1, 0);

    // Asynchronous reset mid-cycle with both slots held
    cyc(1, 32'h77, 5'd7, 1, 0, 0);
    cyc(1, 32'h88, 5'd8, 1, 0, 0);
    @(negedge clk);
    ValidE = 0;
    #3 reset = 1'b1;
    #1;
    q.delete();
    chk("arst_valid", ValidM, 0);
    chk("arst_occ", OccM, 0);
    chk("arst_ready", ReadyE, 1);
    chk("arst_alu", ALUResultM, 0);
    chk("arst_rd", RdM, 0);
    chk("arst_fwd", FwdRdM, 0);
    @(negedge clk);
    reset = 1'b0;

    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      logic [4:0] rd;
      rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      cyc($urandom_range(0, 9) < 7, $urandom, rd, 1'($urandom_range(0, 1)),
          $urandom_range(0, 9) < 6, $urandom_range(0, 39) == 0);
    end
    repeat (4) cyc(0, 0, 0, 0, 1, 0);
    chk("final_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
